// File: rtl/clk_gate_pkg.sv
// Shared constants for the clock-gating cell family.
package clk_gate_pkg;

  localparam int unsigned DRIVE_X4      = 4;
  localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/clk_gate_tst_x4_if.sv
// Enable/observe bundle of the clock-gating cell; CK and RN stay plain ports.
interface clk_gate_tst_x4_if
  import clk_gate_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
);

  logic             E;
  logic             SE;
  logic             GCK;
  logic             EN_Q;
  logic [CNT_W-1:0] PULSE_CNT;

  modport master (
    output E,
    output SE,
    input  GCK,
    input  EN_Q,
    input  PULSE_CNT
  );

  modport slave (
    input  E,
    input  SE,
    output GCK,
    output EN_Q,
    output PULSE_CNT
  );

endinterface

// File: rtl/clk_gate_latch.sv
// Low-transparent enable latch with asynchronous active-low clear.
module clk_gate_latch (
  input  logic CK,
  input  logic RN,
  input  logic D,
  output logic Q
);

  always_latch begin
    if (!RN) begin
      Q <= 1'b0;
    end else if (!CK) begin
      Q <= D;
    end
  end

endmodule

// File: rtl/clk_gate_tst_x4.sv
// Latch-based glitch-free clock gate with scan override, drive X4.
// Define CLKGATE_CNT_EN to build the GCK rising-edge counter on PULSE_CNT.
module clk_gate_tst_x4
  import clk_gate_pkg::*;
#(
  parameter int unsigned DRIVE = DRIVE_X4,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic               CK,
  input  logic               RN,
  clk_gate_tst_x4_if.slave   gif
);

  logic en_d;
  logic en_lat;
  logic gck;

  // Scan enable forces the subtree clock on regardless of the functional enable.
  assign en_d = gif.E | gif.SE;

  clk_gate_latch u_latch (
    .CK (CK),
    .RN (RN),
    .D  (en_d),
    .Q  (en_lat)
  );

  // en_lat is frozen while CK is high, so this AND cannot glitch or truncate a pulse.
  assign gck      = CK & en_lat;
  assign gif.GCK  = gck;
  assign gif.EN_Q = en_lat;

`ifdef CLKGATE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge gck or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign gif.PULSE_CNT = cnt_q;
`else
  assign gif.PULSE_CNT = '0;
`endif

  if (DRIVE == 0 || CNT_W == 0) begin : g_bad_param
    $error("clk_gate_tst_x4: DRIVE and CNT_W must be nonzero");
  end

endmodule

// File: tb/tb_clk_gate_tst_x4.sv
// Self-checking bench for clk_gate_tst_x4 with a phase-level reference model.
module tb_clk_gate_tst_x4;
  import clk_gate_pkg::*;

  localparam int unsigned CNT_W = CNT_W_DEFAULT;

  logic CK;
  logic RN;

  clk_gate_tst_x4_if #(.CNT_W(CNT_W)) gif ();

  clk_gate_tst_x4 #(
    .DRIVE (DRIVE_X4),
    .CNT_W (CNT_W)
  ) dut (
    .CK  (CK),
    .RN  (RN),
    .gif (gif.slave)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the enable that governs the current/next high phase,
  // and the number of complete gated pulses started since reset.
  bit               m_en;
  logic [CNT_W-1:0] m_pulses;

  function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef CLKGATE_CNT_EN
    return m_pulses;
`else
    return '0;
`endif
  endfunction

  function automatic logic exp_gck();
    return CK & m_en;
  endfunction

  task automatic set_en(input logic e, input logic se);
    gif.E  = e;
    gif.SE = se;
    #1;
    if (RN && !CK) m_en = e | se;
  endtask

  task automatic ck_rise();
    #4 CK = 1'b1;
    #1;
    if (RN && m_en) m_pulses = m_pulses + 1'b1;
  endtask

  task automatic ck_fall();
    #4 CK = 1'b0;
    #1;
    if (RN) m_en = gif.E | gif.SE;
  endtask

  task automatic set_rn(input logic v);
    RN = v;
    #1;
    if (!v) begin
      m_en     = 1'b0;
      m_pulses = '0;
    end else if (!CK) begin
      m_en = gif.E | gif.SE;
    end
  endtask

  task automatic test_reset();
    set_en(1'b1, 1'b0);
    set_rn(1'b0);
    for (int i = 0; i < 6; i++) begin
      if (CK) ck_fall(); else ck_rise();
      checks++;
      if (gif.GCK !== 1'b0 || gif.EN_Q !== 1'b0 || gif.PULSE_CNT !== '0) begin
        errors++;
        $display("FAIL reset[%0d]: got GCK=%b EN_Q=%b CNT=%0d, want 0 0 0",
                 i, gif.GCK, gif.EN_Q, gif.PULSE_CNT);
      end
    end
    if (CK) ck_fall();
  endtask

  task automatic test_low_phase();
    set_rn(1'b1);
    for (int v = 0; v < 4; v++) begin
      set_en(v[1], v[0]);
      checks++;
      if (gif.GCK !== 1'b0 || gif.EN_Q !== (v[1] | v[0])) begin
        errors++;
        $display("FAIL low_phase[E=%b SE=%b]: got GCK=%b EN_Q=%b, want GCK=0 EN_Q=%b",
                 v[1], v[0], gif.GCK, gif.EN_Q, v[1] | v[0]);
      end
    end
  endtask

  task automatic test_high_hold();
    set_en(1'b1, 1'b1);
    ck_rise();
    for (int v = 0; v < 4; v++) begin
      set_en(v[1], v[0]);
      checks++;
      if (gif.GCK !== 1'b1 || gif.EN_Q !== 1'b1) begin
        errors++;
        $display("FAIL high_hold[E=%b SE=%b]: got GCK=%b EN_Q=%b, want 1 1",
                 v[1], v[0], gif.GCK, gif.EN_Q);
      end
    end
    ck_fall();
  endtask

  task automatic test_late_enable();
    set_en(1'b0, 1'b0);
    ck_rise();
    set_en(1'b1, 1'b0);
    checks++;
    if (gif.GCK !== 1'b0) begin
      errors++;
      $display("FAIL late_enable_same_phase: got GCK=%b, want 0", gif.GCK);
    end
    ck_fall();
    ck_rise();
    checks++;
    if (gif.GCK !== 1'b1) begin
      errors++;
      $display("FAIL late_enable_next_phase: got GCK=%b, want 1", gif.GCK);
    end
    ck_fall();
  endtask

  task automatic test_scan_override();
    set_rn(1'b0);
    set_rn(1'b1);
    set_en(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      ck_rise();
      checks++;
      if (gif.GCK !== 1'b1) begin
        errors++;
        $display("FAIL scan_pulse[%0d]: got GCK=%b, want 1", i, gif.GCK);
      end
      ck_fall();
    end
    checks++;
`ifdef CLKGATE_CNT_EN
    if (gif.PULSE_CNT !== CNT_W'(5)) begin
`else
    if (gif.PULSE_CNT !== CNT_W'(0)) begin
`endif
      errors++;
      $display("FAIL scan_count: got PULSE_CNT=%0d, want %0d", gif.PULSE_CNT, exp_cnt());
    end
  endtask

  task automatic test_reset_mid_high();
    set_en(1'b1, 1'b0);
    ck_rise();
    checks++;
    if (gif.GCK !== 1'b1) begin
      errors++;
      $display("FAIL mid_high_pre: got GCK=%b, want 1", gif.GCK);
    end
    set_rn(1'b0);
    checks++;
    if (gif.GCK !== 1'b0 || gif.EN_Q !== 1'b0 || gif.PULSE_CNT !== '0) begin
      errors++;
      $display("FAIL mid_high_reset: got GCK=%b EN_Q=%b CNT=%0d, want 0 0 0",
               gif.GCK, gif.EN_Q, gif.PULSE_CNT);
    end
    set_rn(1'b1);
    checks++;
    if (gif.GCK !== 1'b0 || gif.EN_Q !== 1'b0) begin
      errors++;
      $display("FAIL mid_high_release: got GCK=%b EN_Q=%b, want 0 0", gif.GCK, gif.EN_Q);
    end
    ck_fall();
    ck_rise();
    checks++;
    if (gif.GCK !== 1'b1) begin
      errors++;
      $display("FAIL mid_high_resume: got GCK=%b, want 1", gif.GCK);
    end
    ck_fall();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int unsigned act;
      act = $urandom_range(0, 19);
      if (!RN) set_rn(1'b1);
      else if (act < 8) begin
        if (CK) ck_fall(); else ck_rise();
      end else if (act < 18) set_en(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else set_rn(1'b0);
      checks++;
      if (gif.GCK !== exp_gck() || gif.EN_Q !== m_en || gif.PULSE_CNT !== exp_cnt()) begin
        errors++;
        $display("FAIL random[%0d]: got GCK=%b EN_Q=%b CNT=%0d, want %b %b %0d",
                 i, gif.GCK, gif.EN_Q, gif.PULSE_CNT, exp_gck(), m_en, exp_cnt());
      end
    end
  endtask

  initial begin
    CK       = 1'b0;
    RN       = 1'b0;
    gif.E    = 1'b0;
    gif.SE   = 1'b0;
    m_en     = 1'b0;
    m_pulses = '0;
    #2;
    test_reset();
    test_low_phase();
    test_high_hold();
    test_late_enable();
    test_scan_override();
    test_reset_mid_high();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
